// File: rtl/uart_pkg.sv
// Shared UART definitions: transmit FSM states, data width and parity helper.
package uart_pkg;

  localparam int UART_DATA_W = 8;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_t;

  function automatic logic parity8(input logic [UART_DATA_W-1:0] data, input logic odd);
    return (^data) ^ odd;
  endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Single-clock FIFO with registered occupancy count; full blocks a push even
// when a pop happens in the same cycle, and there is no fall-through.
module uart_sync_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rd_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [AW:0]      count_r;
  logic             push_s;
  logic             pop_s;

  assign full    = (count_r == (AW+1)'(DEPTH));
  assign empty   = (count_r == (AW+1)'(0));
  assign push_s  = push && !full;
  assign pop_s   = pop && !empty;
  assign rd_data = mem_r[rd_ptr_r];
  assign count   = count_r;

  // storage array, written at the tail
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= wr_data;
    end
  end

  // pointers wrap naturally at the power-of-two depth
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + (AW+1)'(1);
        2'b01:   count_r <= count_r - (AW+1)'(1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_buffered.sv
// Buffered UART transmitter: byte FIFO feeding an 8-bit LSB-first serialiser
// with optional parity and one or two stop bits, paced by an external baud tick.
module uart_tx_buffered
  import uart_pkg::*;
#(
  parameter int DEPTH      = 8,
  parameter int STOP_BITS  = 1,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     baud_tick,
  input  logic [UART_DATA_W-1:0]   in_data,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic                     tx,
  output logic                     baud_en,
  output logic                     busy,
  output logic [$clog2(DEPTH):0]   fifo_count
);

  localparam int CW = $clog2(DEPTH) + 1;

  tx_state_t              state_r, state_n;
  logic [UART_DATA_W-1:0] shift_r, shift_n;
  logic [2:0]             idx_r, idx_n;
  logic [0:0]             stop_r, stop_n;
  logic                   par_r, par_n;
  logic                   tx_r, tx_n;
  logic                   busy_r;
  logic                   baud_en_r;
  logic                   start_s;
  logic                   pop_s;
  logic                   push_s;
  logic [UART_DATA_W-1:0] head_s;
  logic [CW-1:0]          count_s;
  logic [CW-1:0]          count_nxt_s;
  logic                   full_s;
  logic                   empty_s;

  uart_sync_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (UART_DATA_W)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push    (push_s),
    .wr_data (in_data),
    .pop     (pop_s),
    .rd_data (head_s),
    .count   (count_s),
    .full    (full_s),
    .empty   (empty_s)
  );

  assign in_ready    = !full_s;
  assign push_s      = in_valid && in_ready;
  assign count_nxt_s = count_s + CW'(push_s) - CW'(pop_s);
  assign fifo_count  = count_s;
  assign tx          = tx_r;
  assign busy        = busy_r;
  assign baud_en     = baud_en_r;

  // next-state, serialiser and pop decode; everything advances only on a tick
  always_comb begin
    state_n = state_r;
    shift_n = shift_r;
    idx_n   = idx_r;
    stop_n  = stop_r;
    par_n   = par_r;
    tx_n    = tx_r;
    start_s = 1'b0;
    pop_s   = 1'b0;
    if (baud_tick) begin
      case (state_r)
        IDLE: begin
          if (!empty_s) begin
            start_s = 1'b1;
          end else begin
            tx_n = 1'b1;
          end
        end
        START: begin
          tx_n    = shift_r[0];
          shift_n = {1'b0, shift_r[UART_DATA_W-1:1]};
          idx_n   = 3'd0;
          state_n = DATA;
        end
        DATA: begin
          if (idx_r == 3'd7) begin
            if (PARITY_EN != 0) begin
              tx_n    = par_r;
              state_n = PARITY;
            end else begin
              tx_n    = 1'b1;
              stop_n  = 1'b0;
              state_n = STOP;
            end
          end else begin
            tx_n    = shift_r[0];
            shift_n = {1'b0, shift_r[UART_DATA_W-1:1]};
            idx_n   = idx_r + 3'd1;
          end
        end
        PARITY: begin
          tx_n    = 1'b1;
          stop_n  = 1'b0;
          state_n = STOP;
        end
        STOP: begin
          if (stop_r == 1'(STOP_BITS - 1)) begin
            if (!empty_s) begin
              start_s = 1'b1;
            end else begin
              tx_n    = 1'b1;
              state_n = IDLE;
            end
          end else begin
            stop_n = stop_r + 1'b1;
          end
        end
        default: begin
          tx_n    = 1'b1;
          state_n = IDLE;
        end
      endcase
    end else begin
      state_n = state_r;
    end
    // a frame start pops the head byte and drives the start bit on the same edge
    if (start_s) begin
      pop_s   = 1'b1;
      shift_n = head_s;
      par_n   = parity8(head_s, 1'(PARITY_ODD));
      tx_n    = 1'b0;
      state_n = START;
    end else begin
      pop_s = 1'b0;
    end
  end

  // FSM, datapath and registered status outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= IDLE;
      shift_r   <= '0;
      idx_r     <= 3'd0;
      stop_r    <= 1'b0;
      par_r     <= 1'b0;
      tx_r      <= 1'b1;
      busy_r    <= 1'b0;
      baud_en_r <= 1'b0;
    end else begin
      state_r   <= state_n;
      shift_r   <= shift_n;
      idx_r     <= idx_n;
      stop_r    <= stop_n;
      par_r     <= par_n;
      tx_r      <= tx_n;
      busy_r    <= (state_n != IDLE);
      baud_en_r <= (state_n != IDLE) || (count_nxt_s != CW'(0));
    end
  end

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Self-checking bench: four transmitter variants (8N1, 8E1, 8O1, 8N2) compared
// cycle by cycle against a queue-based line model of the serial output.
module tb_uart_tx_buffered;

  localparam logic [3:0] PE_V = 4'b0110;
  localparam logic [3:0] PO_V = 4'b0100;
  localparam logic [3:0] S2_V = 4'b1000;

  logic       clk;
  logic       rst_n;
  logic       baud_tick;
  logic [7:0] in_data;
  logic [3:0] in_valid_v;
  logic [3:0] in_ready_w;
  logic [3:0] tx_w;
  logic [3:0] busy_w;
  logic [3:0] baud_en_w;
  logic [3:0] fc_w [4];

  for (genvar g = 0; g < 4; g++) begin : g_dut
    uart_tx_buffered #(
      .DEPTH      (8),
      .STOP_BITS  (S2_V[g] ? 2 : 1),
      .PARITY_EN  (PE_V[g] ? 1 : 0),
      .PARITY_ODD (PO_V[g] ? 1 : 0)
    ) u_dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .baud_tick  (baud_tick),
      .in_data    (in_data),
      .in_valid   (in_valid_v[g]),
      .in_ready   (in_ready_w[g]),
      .tx         (tx_w[g]),
      .baud_en    (baud_en_w[g]),
      .busy       (busy_w[g]),
      .fifo_count (fc_w[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int         n_cmp = 0;
  int         n_err = 0;
  int         cur   = 0;
  logic [7:0] mq[$];
  bit         mbits[$];
  bit         mtx   = 1'b1;
  bit         mbusy = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s dut=%0d observed=%0h expected=%0h", tag, cur, obs, exp);
    end
  endtask

  // serial image of one frame: start, data LSB first, optional parity, stops
  task automatic build(input logic [7:0] b);
    int ones;
    ones = 0;
    mbits.push_back(1'b0);
    for (int i = 0; i < 8; i++) begin
      mbits.push_back(((b >> i) & 8'd1) != 8'd0);
      ones += int'((b >> i) & 8'd1);
    end
    if (PE_V[cur]) mbits.push_back(((ones % 2) == 1) ^ PO_V[cur]);
    for (int i = 0; i < (S2_V[cur] ? 2 : 1); i++) mbits.push_back(1'b1);
  endtask

  task automatic model_clear();
    mq.delete();
    mbits.delete();
    mtx   = 1'b1;
    mbusy = 1'b0;
  endtask

  task automatic cyc(input bit tk, input bit vld, input logic [7:0] d, output bit acc);
    baud_tick  = tk;
    in_valid_v = vld ? (4'b0001 << cur) : 4'b0000;
    in_data    = d;
    acc = vld && (mq.size() < 8);
    if (tk) begin
      if (mbits.size() > 0) begin
        mtx = mbits.pop_front();
      end else if (mq.size() > 0) begin
        build(mq.pop_front());
        mtx   = mbits.pop_front();
        mbusy = 1'b1;
      end else begin
        mtx   = 1'b1;
        mbusy = 1'b0;
      end
    end
    if (acc) mq.push_back(d);
    @(posedge clk);
    #1;
    baud_tick  = 1'b0;
    in_valid_v = 4'b0000;
    chk("tx", tx_w[cur], mtx);
    chk("busy", busy_w[cur], mbusy);
    chk("baud_en", baud_en_w[cur], mbusy || (mq.size() > 0));
    chk("fifo_count", fc_w[cur], mq.size());
    chk("in_ready", in_ready_w[cur], mq.size() < 8);
  endtask

  task automatic drain();
    int guard;
    bit acc;
    guard = 0;
    while ((mbusy || mq.size() > 0) && guard < 3000) begin
      cyc($urandom_range(0, 2) == 0, 1'b0, 8'h00, acc);
      guard++;
    end
    chk("drain_timeout", guard < 3000, 1'b1);
  endtask

  task automatic push_seq(input logic [7:0] a, input logic [7:0] b, input int n);
    bit acc;
    cyc(1'b0, 1'b1, a, acc);
    if (n > 1) cyc(1'b0, 1'b1, b, acc);
  endtask

  initial begin
    bit         acc;
    int         n;
    int         pushed;
    int         guard;
    logic [7:0] d;

    rst_n      = 1'b0;
    baud_tick  = 1'b0;
    in_data    = 8'h00;
    in_valid_v = 4'b0000;
    repeat (3) @(posedge clk);
    #1;
    for (int g = 0; g < 4; g++) begin
      cur = g;
      chk("rst_tx", tx_w[g], 1'b1);
      chk("rst_busy", busy_w[g], 1'b0);
      chk("rst_baud_en", baud_en_w[g], 1'b0);
      chk("rst_fifo_count", fc_w[g], 4'd0);
      chk("rst_in_ready", in_ready_w[g], 1'b1);
    end
    rst_n = 1'b1;
    cur   = 0;

    // ticks with an empty FIFO are ignored
    repeat (5) cyc(1'b1, 1'b0, 8'h00, acc);

    // single byte, then back-to-back pair, on 8N1
    push_seq(8'hB4, 8'h00, 1);
    drain();
    push_seq(8'hB4, 8'hF1, 2);
    drain();

    // burst into a full FIFO; ninth byte waits for the first pop
    for (int i = 0; i < 9; i++) cyc(1'b0, 1'b1, 8'h10 + 8'(i), acc);
    chk("burst_count", fc_w[0], 4'd8);
    chk("burst_ready", in_ready_w[0], 1'b0);
    cyc(1'b1, 1'b1, 8'h19, acc);
    chk("burst_full_push_blocked", acc, 1'b0);
    cyc(1'b0, 1'b1, 8'h19, acc);
    chk("burst_late_accept", acc, 1'b1);
    drain();

    // parity variants and two stop bits
    cur = 1; push_seq(8'hF1, 8'h00, 1); drain();
    cur = 1; push_seq(8'hA5, 8'h00, 1); drain();
    cur = 2; push_seq(8'hF1, 8'h00, 1); drain();
    cur = 3; push_seq(8'h00, 8'h5A, 2); drain();

    // reset during bit 3 of 0xA5 with two bytes still queued
    cur = 0;
    cyc(1'b0, 1'b1, 8'hA5, acc);
    cyc(1'b0, 1'b1, 8'h3C, acc);
    cyc(1'b0, 1'b1, 8'hC3, acc);
    repeat (5) cyc(1'b1, 1'b0, 8'h00, acc);
    chk("pre_reset_bit3", tx_w[0], 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    for (int g = 0; g < 4; g++) begin
      cur = g;
      chk("midrst_tx", tx_w[g], 1'b1);
      chk("midrst_busy", busy_w[g], 1'b0);
      chk("midrst_baud_en", baud_en_w[g], 1'b0);
      chk("midrst_fifo_count", fc_w[g], 4'd0);
    end
    cur = 0;
    model_clear();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (40) cyc(1'b1, 1'b0, 8'h00, acc);

    // randomized bursts with random tick spacing on random variants
    for (int it = 0; it < 12; it++) begin
      cur    = int'($urandom_range(0, 3));
      n      = int'($urandom_range(1, 10));
      pushed = 0;
      guard  = 0;
      while (pushed < n && guard < 500) begin
        d = 8'($urandom);
        cyc($urandom_range(0, 2) == 0, $urandom_range(0, 1) == 1, d, acc);
        if (acc) pushed++;
        guard++;
      end
      chk("push_timeout", guard < 500, 1'b1);
      drain();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
